mul_share_ctrl: RTL and testbench



---
 rtl/mul_share_pkg.sv | 14 +
 rtl/mul_share_ctrl_if.sv | 31 +++
 rtl/mul_seq_core.sv | 62 ++++++
 rtl/mul_share_ctrl.sv | 93 +++++++++
 tb/tb_mul_share_ctrl.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/mul_share_pkg.sv
// rtl/mul_share_pkg.sv - shared types and constants for the shared multiplier
package mul_share_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  typedef logic req_id_t;

endpackage

// File: rtl/mul_share_ctrl_if.sv
// rtl/mul_share_ctrl_if.sv - two-requester request/result bundle for the shared multiplier
interface mul_share_ctrl_if
  import mul_share_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic               req0;
  logic [WIDTH-1:0]   op_a0;
  logic [WIDTH-1:0]   op_b0;
  logic               req1;
  logic [WIDTH-1:0]   op_a1;
  logic [WIDTH-1:0]   op_b1;
  logic               done0;
  logic               done1;
  logic [2*WIDTH-1:0] result;
  logic               busy;

  // Client side: raises requests and operands, watches completions.
  modport master (
    output req0, op_a0, op_b0, req1, op_a1, op_b1,
    input  done0, done1, result, busy
  );

  // Multiplier side.
  modport slave (
    input  req0, op_a0, op_b0, req1, op_a1, op_b1,
    output done0, done1, result, busy
  );

endinterface

// File: rtl/mul_seq_core.sv
// rtl/mul_seq_core.sv - shift-add multiply engine, one multiplier bit per cycle
module mul_seq_core
  import mul_share_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product,
  output logic               fin
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic               running;
  logic [2*WIDTH-1:0] acc_next;

  // Next accumulator value; on the last bit this is already the full product,
  // so the controller can capture it on the same edge the last bit is consumed.
  always_comb begin
    acc_next = acc;
    if (mplier[0]) begin
      acc_next = acc + mcand;
    end
    product = acc_next;
    fin     = running && (cnt == LAST);
  end

  // Latch operands on start, then consume one multiplier bit per cycle; no early exit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      running <= 1'b0;
    end else if (start) begin
      acc     <= '0;
      mcand   <= {{WIDTH{1'b0}}, a};
      mplier  <= b;
      cnt     <= '0;
      running <= 1'b1;
    end else if (running) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
      if (fin) begin
        running <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mul_share_ctrl.sv
// rtl/mul_share_ctrl.sv - round-robin shared 8x8 multiplier service for two clients
module mul_share_ctrl
  import mul_share_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic           clk,
  input  logic           rst,
  mul_share_ctrl_if.slave bus
);

  state_t             state;
  req_id_t            last_grant;
  req_id_t            grant_id;
  req_id_t            grant;
  logic               start;
  logic [WIDTH-1:0]   win_a;
  logic [WIDTH-1:0]   win_b;
  logic [2*WIDTH-1:0] core_product;
  logic               core_fin;
  logic               done0_q;
  logic               done1_q;
  logic               busy_q;
  logic [2*WIDTH-1:0] result_q;

  // Arbitration: a lone request wins; on a tie the side not served last wins.
  always_comb begin
    grant = 1'b0;
    if (bus.req0 && bus.req1) begin
      grant = ~last_grant;
    end else if (bus.req1) begin
      grant = 1'b1;
    end
    win_a = grant ? bus.op_a1 : bus.op_a0;
    win_b = grant ? bus.op_b1 : bus.op_b0;
    start = (state == IDLE) && (bus.req0 || bus.req1);
  end

  mul_seq_core #(.WIDTH(WIDTH)) u_core (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (win_a),
    .b       (win_b),
    .product (core_product),
    .fin     (core_fin)
  );

  // Service FSM with registered done/busy/result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant_id   <= 1'b0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      busy_q     <= 1'b0;
      result_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            grant_id   <= grant;
            last_grant <= grant;
            busy_q     <= 1'b1;
            state      <= RUN;
          end
        end
        RUN: begin
          if (core_fin) begin
            result_q <= core_product;
            done0_q  <= (grant_id == 1'b0);
            done1_q  <= (grant_id == 1'b1);
            state    <= DONE;
          end
        end
        DONE: begin
          done0_q <= 1'b0;
          done1_q <= 1'b0;
          busy_q  <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.done0  = done0_q;
  assign bus.done1  = done1_q;
  assign bus.busy   = busy_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_mul_share_ctrl.sv
// tb/tb_mul_share_ctrl.sv - directed scoreboard bench for the shared multiplier
module tb_mul_share_ctrl;
  import mul_share_pkg::*;

  localparam int W = 8;

  typedef struct packed {
    logic        id;
    logic [15:0] res;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fails  = 0;
  int   c;

  always #5 clk = ~clk;

  mul_share_ctrl_if #(.WIDTH(W)) bus ();

  mul_share_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input logic id, input logic [15:0] res);
    exp_t e;
    e.id  = id;
    e.res = res;
    sb.push_back(e);
  endtask

  task automatic wait_done(input string tag, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!(bus.done0 || bus.done1) && cycles < 40);
    check({tag, "_seen"}, {31'b0, bus.done0 | bus.done1}, 32'd1);
  endtask

  // Scoreboard: every done pulse pops the oldest expectation.
  always @(negedge clk) begin
    if (!rst && (bus.done0 || bus.done1)) begin
      check("done_overlap", {31'b0, bus.done0 & bus.done1}, 32'd0);
      check("sb_nonempty", {31'b0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("done_id", {31'b0, bus.done1}, {31'b0, mon_e.id});
        check("result", {16'b0, bus.result}, {16'b0, mon_e.res});
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.req0 = 1'b0; bus.op_a0 = '0; bus.op_b0 = '0;
    bus.req1 = 1'b0; bus.op_a1 = '0; bus.op_b1 = '0;
    repeat (2) @(negedge clk);
    check("rst_done0", {31'b0, bus.done0}, 32'd0);
    check("rst_done1", {31'b0, bus.done1}, 32'd0);
    check("rst_busy", {31'b0, bus.busy}, 32'd0);
    check("rst_result", {16'b0, bus.result}, 32'd0);
    rst = 1'b0;

    // Solo requester 0
    bus.op_a0 = 8'd2; bus.op_b0 = 8'd3; push(1'b0, 16'd6);
    bus.req0 = 1'b1;
    wait_done("t1", c);
    check("t1_latency", c, 32'd9);
    check("t1_done1_low", {31'b0, bus.done1}, 32'd0);
    bus.req0 = 1'b0;
    @(negedge clk);
    check("t1_done0_once", {31'b0, bus.done0}, 32'd0);
    check("t1_busy_low", {31'b0, bus.busy}, 32'd0);

    // Simultaneous requests straight after reset
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.op_a0 = 8'd4; bus.op_b0 = 8'd6; bus.op_a1 = 8'd3; bus.op_b1 = 8'd3;
    push(1'b0, 16'd24); push(1'b1, 16'd9);
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    wait_done("t2a", c);
    check("t2_first_latency", c, 32'd9);
    check("t2_first_is_0", {31'b0, bus.done0}, 32'd1);
    bus.req0 = 1'b0;
    wait_done("t2b", c);
    check("t2_second_gap", c, 32'd10);
    check("t2_second_is_1", {31'b0, bus.done1}, 32'd1);
    bus.req1 = 1'b0;
    @(negedge clk);

    // Both held: grants alternate 0,1,0,1
    bus.op_a0 = 8'd10; bus.op_b0 = 8'd11; bus.op_a1 = 8'd12; bus.op_b1 = 8'd13;
    push(1'b0, 16'd110); push(1'b1, 16'd156);
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    wait_done("t3a", c);
    check("t3_g0", {31'b0, bus.done0}, 32'd1);
    bus.op_a0 = 8'd20; bus.op_b0 = 8'd21; push(1'b0, 16'd420);
    wait_done("t3b", c);
    check("t3_g1", {31'b0, bus.done1}, 32'd1);
    check("t3_gap1", c, 32'd10);
    bus.op_a1 = 8'd30; bus.op_b1 = 8'd31; push(1'b1, 16'd930);
    wait_done("t3c", c);
    check("t3_g2", {31'b0, bus.done0}, 32'd1);
    check("t3_gap2", c, 32'd10);
    bus.req0 = 1'b0;
    wait_done("t3d", c);
    check("t3_g3", {31'b0, bus.done1}, 32'd1);
    check("t3_gap3", c, 32'd10);
    bus.req1 = 1'b0;
    @(negedge clk);

    // Boundary operands
    bus.op_a0 = 8'd0; bus.op_b0 = 8'd200; push(1'b0, 16'd0);
    bus.req0 = 1'b1;
    wait_done("t4a", c);
    check("t4_zero_a_latency", c, 32'd9);
    bus.req0 = 1'b0;
    @(negedge clk);
    bus.op_a1 = 8'd200; bus.op_b1 = 8'd0; push(1'b1, 16'd0);
    bus.req1 = 1'b1;
    wait_done("t4b", c);
    check("t4_zero_b_latency", c, 32'd9);
    bus.req1 = 1'b0;
    @(negedge clk);
    bus.op_a0 = 8'd255; bus.op_b0 = 8'd255; push(1'b0, 16'd65025);
    bus.req0 = 1'b1;
    wait_done("t4c", c);
    check("t4_max_latency", c, 32'd9);
    bus.req0 = 1'b0;
    repeat (3) @(negedge clk);
    check("t4_result_hold", {16'b0, bus.result}, 32'd65025);

    // Reset on the 4th RUN cycle of 7*9
    bus.op_a0 = 8'd7; bus.op_b0 = 8'd9;
    bus.req0 = 1'b1;
    repeat (4) @(negedge clk);
    check("t5_busy_before", {31'b0, bus.busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("t5_rst_done0", {31'b0, bus.done0}, 32'd0);
    check("t5_rst_done1", {31'b0, bus.done1}, 32'd0);
    check("t5_rst_busy", {31'b0, bus.busy}, 32'd0);
    check("t5_rst_result", {16'b0, bus.result}, 32'd0);
    push(1'b0, 16'd63);
    @(negedge clk);
    rst = 1'b0;
    wait_done("t5", c);
    check("t5_regrant_latency", c, 32'd9);
    check("t5_done0", {31'b0, bus.done0}, 32'd1);
    bus.req0 = 1'b0;
    @(negedge clk);

    // req1 raised while busy; op_a0 changed mid-RUN
    bus.op_a0 = 8'd5; bus.op_b0 = 8'd6; push(1'b0, 16'd30);
    bus.req0 = 1'b1;
    repeat (2) @(negedge clk);
    bus.op_a1 = 8'd9; bus.op_b1 = 8'd9; push(1'b1, 16'd81);
    bus.req1 = 1'b1;
    repeat (2) @(negedge clk);
    bus.op_a0 = 8'd100;
    wait_done("t6a", c);
    check("t6_first_latency", c, 32'd5);
    check("t6_done0", {31'b0, bus.done0}, 32'd1);
    bus.req0 = 1'b0;
    wait_done("t6b", c);
    check("t6_pending_gap", c, 32'd10);
    check("t6_done1", {31'b0, bus.done1}, 32'd1);
    bus.req1 = 1'b0;

    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 32'd0);
    check("final_busy", {31'b0, bus.busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
